divider_unit: RTL and testbench
===============================

# divider_unit

Sequential 8-bit unsigned restoring divider, the inverse companion to the shift-add multiplier datapath on the same board. Divisor is loaded from the slide switches, then Execute captures the dividend from the same switches. Quotient and remainder are produced by a one-bit-per-iteration shift/trial-subtract loop. Results hold on the hex displays until Execute is released, matching the multiplier's run/hold behaviour.

## Interface
- WIDTH, 8, operand width; dividend, divisor, quotient and remainder are all WIDTH bits
- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high; clears all registers and returns FSM to IDLE
- LoadDivisor  input  1  level; in IDLE loads Switches into divisor register, clears Qval/Rval/DivZero
- Execute  input  1  level; sampled high in IDLE starts a division; must drop before the next run
- Switches  input  WIDTH  operand source (divisor on LoadDivisor, dividend on start)
- Qval  output  WIDTH  quotient register; holds dividend bits during operation
- Rval  output  WIDTH  partial/final remainder register
- Dval  output  WIDTH  divisor register
- Busy  output  1  high in LOAD, SHIFT, TRIAL
- DivZero  output  1  set when a run starts with Dval == 0; cleared by next LoadDivisor or Reset
- States  output  8  debug: [3:0] state code, [7:4] iteration count

## Operation
- FSM states: IDLE, LOAD, SHIFT, TRIAL, HOLD
- IDLE: LoadDivisor=1 -> Dval<=Switches, Qval<=0, Rval<=0, DivZero<=0, stay IDLE. Else Execute=1 -> LOAD. LoadDivisor has priority over Execute in the same cycle.
- LOAD: Qval<=Switches, Rval<=0, count<=0. If Dval==0: DivZero<=1, Qval<={WIDTH{1}}, Rval<=Switches, go to HOLD. Else go to SHIFT.
- SHIFT: {Rval,Qval}<={Rval,Qval}<<1, Qval[0]<=0, then go to TRIAL.
- TRIAL: T = {1'b0,Rval} - {1'b0,Dval} (WIDTH+1 bits). If T[WIDTH]==0: Rval<=T[WIDTH-1:0], Qval[0]<=1. Otherwise restore: no change. count<=count+1. If count==WIDTH-1, go to HOLD; else go to SHIFT.
- HOLD: registers frozen. Execute=0 -> IDLE. Execute=1 -> stay (no auto-restart).
- LoadDivisor is ignored outside IDLE. Switches is ignored except in the IDLE-load and LOAD cycles.
- Unsigned arithmetic only. Rval < Dval always holds after each TRIAL, so no carry beyond WIDTH bits is needed.
- States[3:0] codes: IDLE=0, LOAD=1, SHIFT=2, TRIAL=4, HOLD=8.

## Timing
- Reset values: Qval=0, Rval=0, Dval=0, Busy=0, DivZero=0, States=8'h00. Reset takes effect immediately (asynchronous), including mid-division.
- Execute seen high in IDLE during cycle t:
  - LOAD in t+1
  - SHIFT/TRIAL pairs occupy t+2..t+2*WIDTH+1
  - HOLD from t+2*WIDTH+2 (t+18 for WIDTH=8), with final Qval/Rval valid there
- Busy is high for 2*WIDTH+1 cycles.
- Divide-by-zero: HOLD at t+2, Busy high for exactly one cycle.
- HOLD -> IDLE one cycle after Execute is sampled low. A new run needs Execute high again in IDLE.
- LoadDivisor effect is visible on Dval the cycle after it is sampled.

## Structure
- Package divider_pkg holds:
  - state enum div_state_t
  - 4-bit state debug code constants
  - default WIDTH constant
- One sub-module, div_datapath, holds the Qval/Rval/Dval registers and the WIDTH+1-bit trial subtractor. Its controls are ld_div, ld_op, zero_fix, shift, trial; it returns the borrow and a divisor-zero flag.
- FSM and iteration counter live in divider_unit.

## Test plan
- LoadDivisor with Switches=0x07, then Execute with Switches=0x64 -> Qval=0x0E, Rval=0x02, Busy high 17 cycles, HOLD at t+18.
- Divisor 0x00, Execute with 0x55 -> DivZero=1, Qval=0xFF, Rval=0x55, HOLD at t+2; a later LoadDivisor 0x03 clears DivZero.
- Edge operands:
  - divisor 0xFF, dividend 0xFE -> Q=0x00, R=0xFE
  - divisor 0x01, dividend 0xFF -> Q=0xFF, R=0x00
  - divisor 0x81, dividend 0xFF -> Q=0x01, R=0x7E
- Reset pulsed during the third TRIAL -> all outputs 0 immediately, States=0x00; a subsequent run with divisor 0x05, dividend 0x11 gives Q=0x03, R=0x02.
- Execute held high through completion -> remains in HOLD 10+ cycles with stable results.
  - Release Execute -> IDLE one cycle later.
  - LoadDivisor pulsed while Busy -> Dval unchanged.
- LoadDivisor and Execute both high in IDLE with Switches=0x09 -> Dval=0x09 that cycle, no start.
  - Execute still high next cycle -> run starts, giving Q=0x01, R=0x00.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  localparam logic [3:0] CODE_IDLE  = 4'h0;
  localparam logic [3:0] CODE_LOAD  = 4'h1;
  localparam logic [3:0] CODE_SHIFT = 4'h2;
  localparam logic [3:0] CODE_TRIAL = 4'h4;
  localparam logic [3:0] CODE_HOLD  = 4'h8;

  // Encodings equal the debug codes so the state register drives States[3:0] directly.
  typedef enum logic [3:0] {
    S_IDLE  = CODE_IDLE,
    S_LOAD  = CODE_LOAD,
    S_SHIFT = CODE_SHIFT,
    S_TRIAL = CODE_TRIAL,
    S_HOLD  = CODE_HOLD
  } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Quotient/remainder/divisor registers with the WIDTH+1-bit trial subtractor.
module div_datapath
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_div,
  input  logic             ld_op,
  input  logic             zero_fix,
  input  logic             shift,
  input  logic             trial,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             d_zero
);

  logic [WIDTH:0] diff;

  assign diff   = {1'b0, r} - {1'b0, d};
  assign borrow = diff[WIDTH];
  assign d_zero = (d == '0);

  // trial is only asserted when the subtraction did not borrow; restore is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (ld_div) begin
      d <= sw;
      q <= '0;
      r <= '0;
    end else if (zero_fix) begin
      q <= '1;
      r <= sw;
    end else if (ld_op) begin
      q <= sw;
      r <= '0;
    end else if (shift) begin
      {r, q} <= {r[WIDTH-2:0], q, 1'b0};
    end else if (trial) begin
      r    <= diff[WIDTH-1:0];
      q[0] <= 1'b1;
    end
  end

endmodule

// File: rtl/divider_unit.sv
// Restoring divider control: load/shift/trial sequencing, iteration count and run/hold handshake.
module divider_unit
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadDivisor,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Switches,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic [WIDTH-1:0] Dval,
  output logic             Busy,
  output logic             DivZero,
  output logic [7:0]       States
);

  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  div_state_t state;
  logic [3:0] count;
  logic       div_zero;
  logic       ld_div, ld_op, zero_fix, shift, trial;
  logic       borrow, d_zero;

  always_comb begin
    ld_div   = (state == S_IDLE) && LoadDivisor;
    ld_op    = (state == S_LOAD);
    zero_fix = (state == S_LOAD) && d_zero;
    shift    = (state == S_SHIFT);
    trial    = (state == S_TRIAL) && !borrow;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      count    <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (LoadDivisor)  div_zero <= 1'b0;
          else if (Execute) state    <= S_LOAD;
        end
        S_LOAD: begin
          count <= '0;
          if (d_zero) begin
            div_zero <= 1'b1;
            state    <= S_HOLD;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_SHIFT: state <= S_TRIAL;
        S_TRIAL: begin
          count <= count + 4'd1;
          state <= (count == CNT_LAST) ? S_HOLD : S_SHIFT;
        end
        S_HOLD: if (!Execute) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (Clk),
    .rst      (Reset),
    .ld_div   (ld_div),
    .ld_op    (ld_op),
    .zero_fix (zero_fix),
    .shift    (shift),
    .trial    (trial),
    .sw       (Switches),
    .q        (Qval),
    .r        (Rval),
    .d        (Dval),
    .borrow   (borrow),
    .d_zero   (d_zero)
  );

  assign Busy    = (state == S_LOAD) || (state == S_SHIFT) || (state == S_TRIAL);
  assign DivZero = div_zero;
  assign States  = {count, state};

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: scoreboard of expected {quotient, remainder} per run.
module tb_divider_unit;

  logic       Clk = 1'b0;
  logic       Reset, LoadDivisor, Execute;
  logic [7:0] Switches;
  logic [7:0] Qval, Rval, Dval, States;
  logic       Busy, DivZero;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  divider_unit #(.WIDTH(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .LoadDivisor (LoadDivisor),
    .Execute     (Execute),
    .Switches    (Switches),
    .Qval        (Qval),
    .Rval        (Rval),
    .Dval        (Dval),
    .Busy        (Busy),
    .DivZero     (DivZero),
    .States      (States)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Loads a divisor, starts a run and waits (bounded) for HOLD; returns latency and busy cycles.
  task automatic do_run(input logic [7:0] dvs, input logic [7:0] dvd, input bit ld_pulse,
                        output int lat, output int busy_n, output bit timeout);
    @(negedge Clk);
    LoadDivisor = 1'b1;
    Switches    = dvs;
    @(negedge Clk);
    LoadDivisor = 1'b0;
    Switches    = dvd;
    Execute     = 1'b1;
    if (dvs == 8'h00) exp_q.push_back({8'hFF, dvd});
    else              exp_q.push_back({8'(dvd / dvs), 8'(dvd % dvs)});
    lat = 0; busy_n = 0; timeout = 1'b0;
    while (1) begin
      @(negedge Clk);
      lat++;
      if (Busy === 1'b1) busy_n++;
      if (lat >= 2) Switches = 8'($urandom);
      LoadDivisor = ld_pulse && (lat >= 3) && (lat <= 5);
      if (States[3:0] === 4'h8) break;
      if (lat >= 60) begin timeout = 1'b1; break; end
    end
    LoadDivisor = 1'b0;
  endtask

  task automatic release_exec();
    Execute = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; LoadDivisor = 1'b0; Execute = 1'b0; Switches = 8'h00;
    #1;
    checks++;
    if ({Qval, Rval, Dval, Busy, DivZero, States} !== 34'h0) begin
      failures++;
      $display("FAIL reset_values got q=%h r=%h d=%h busy=%b dz=%b st=%h expected all zero",
               Qval, Rval, Dval, Busy, DivZero, States);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bn; bit to; logic [15:0] e;
    do_run(8'h07, 8'h64, 1'b0, lat, bn, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout got no HOLD within bound, required HOLD"); end
    checks++;
    if (Qval !== e[15:8]) begin failures++; $display("FAIL basic_q got %h required %h", Qval, e[15:8]); end
    checks++;
    if (Rval !== e[7:0]) begin failures++; $display("FAIL basic_r got %h required %h", Rval, e[7:0]); end
    checks++;
    if (lat !== 18) begin failures++; $display("FAIL basic_latency got %0d required 18", lat); end
    checks++;
    if (bn !== 17) begin failures++; $display("FAIL basic_busy_cycles got %0d required 17", bn); end
    checks++;
    if (DivZero !== 1'b0) begin failures++; $display("FAIL basic_divzero got %b required 0", DivZero); end
    checks++;
    if (States !== 8'h88) begin failures++; $display("FAIL basic_states got %h required 88", States); end
    release_exec();
  endtask

  task automatic test_div_zero();
    int lat, bn; bit to; logic [15:0] e;
    do_run(8'h00, 8'h55, 1'b0, lat, bn, to);
    e = exp_q.pop_front();
    checks++;
    if (DivZero !== 1'b1) begin failures++; $display("FAIL dz_flag got %b required 1", DivZero); end
    checks++;
    if ({Qval, Rval} !== e) begin failures++; $display("FAIL dz_result got q=%h r=%h required q=%h r=%h", Qval, Rval, e[15:8], e[7:0]); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL dz_latency got %0d required 2", lat); end
    checks++;
    if (bn !== 1) begin failures++; $display("FAIL dz_busy_cycles got %0d required 1", bn); end
    release_exec();
    @(negedge Clk);
    LoadDivisor = 1'b1;
    Switches    = 8'h03;
    @(negedge Clk);
    LoadDivisor = 1'b0;
    checks++;
    if (DivZero !== 1'b0 || Dval !== 8'h03) begin
      failures++;
      $display("FAIL dz_clear got dz=%b d=%h required dz=0 d=03", DivZero, Dval);
    end
  endtask

  task automatic test_edges();
    logic [7:0] dvs_t[3] = '{8'hFF, 8'h01, 8'h81};
    logic [7:0] dvd_t[3] = '{8'hFE, 8'hFF, 8'hFF};
    int lat, bn; bit to; logic [15:0] e;
    for (int i = 0; i < 3; i++) begin
      do_run(dvs_t[i], dvd_t[i], 1'b0, lat, bn, to);
      e = exp_q.pop_front();
      checks++;
      if (to || {Qval, Rval} !== e) begin
        failures++;
        $display("FAIL edge_%0d got q=%h r=%h required q=%h r=%h", i, Qval, Rval, e[15:8], e[7:0]);
      end
      checks++;
      if (lat !== 18) begin failures++; $display("FAIL edge_latency_%0d got %0d required 18", i, lat); end
      release_exec();
    end
  endtask

  task automatic test_reset_mid();
    int trials = 0, n = 0, lat, bn; bit to; logic [15:0] e;
    @(negedge Clk);
    LoadDivisor = 1'b1; Switches = 8'h3C;
    @(negedge Clk);
    LoadDivisor = 1'b0; Switches = 8'hF0; Execute = 1'b1;
    exp_q.push_back({8'(8'hF0 / 8'h3C), 8'(8'hF0 % 8'h3C)});
    while (trials < 3 && n < 40) begin
      @(negedge Clk);
      n++;
      if (States[3:0] === 4'h4) trials++;
    end
    checks++;
    if (trials != 3) begin failures++; $display("FAIL midreset_reach got %0d trials required 3", trials); end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({Qval, Rval, Dval, Busy, DivZero, States} !== 34'h0) begin
      failures++;
      $display("FAIL midreset_clear got q=%h r=%h d=%h busy=%b dz=%b st=%h required all zero",
               Qval, Rval, Dval, Busy, DivZero, States);
    end
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b0; Execute = 1'b0;
    do_run(8'h05, 8'h11, 1'b0, lat, bn, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {Qval, Rval} !== e) begin
      failures++;
      $display("FAIL midreset_rerun got q=%h r=%h required q=%h r=%h", Qval, Rval, e[15:8], e[7:0]);
    end
    release_exec();
  endtask

  task automatic test_hold();
    int lat, bn, bad = 0; bit to; logic [15:0] e;
    do_run(8'h0C, 8'hC8, 1'b1, lat, bn, to);
    e = exp_q.pop_front();
    checks++;
    if (Dval !== 8'h0C) begin failures++; $display("FAIL hold_ld_ignored got d=%h required 0c", Dval); end
    checks++;
    if (to || {Qval, Rval} !== e) begin
      failures++;
      $display("FAIL hold_result got q=%h r=%h required q=%h r=%h", Qval, Rval, e[15:8], e[7:0]);
    end
    repeat (12) begin
      @(negedge Clk);
      if (States[3:0] !== 4'h8 || {Qval, Rval} !== e || Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hold_stable got %0d bad cycles required 0", bad); end
    release_exec();
    checks++;
    if (States[3:0] !== 4'h0) begin failures++; $display("FAIL hold_release got state %h required 0", States[3:0]); end
  endtask

  task automatic test_priority();
    int n = 0; logic [15:0] e;
    @(negedge Clk);
    LoadDivisor = 1'b1; Execute = 1'b1; Switches = 8'h09;
    @(negedge Clk);
    checks++;
    if (Dval !== 8'h09 || States[3:0] !== 4'h0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL prio_load got d=%h state=%h busy=%b required d=09 state=0 busy=0", Dval, States[3:0], Busy);
    end
    LoadDivisor = 1'b0;
    exp_q.push_back({8'(8'h09 / 8'h09), 8'(8'h09 % 8'h09)});
    @(negedge Clk);
    checks++;
    if (States[3:0] !== 4'h1) begin failures++; $display("FAIL prio_start got state %h required 1", States[3:0]); end
    while (States[3:0] !== 4'h8 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (States[3:0] !== 4'h8 || {Qval, Rval} !== e) begin
      failures++;
      $display("FAIL prio_result got q=%h r=%h state=%h required q=%h r=%h in HOLD",
               Qval, Rval, States[3:0], e[15:8], e[7:0]);
    end
    release_exec();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_edges();
    test_reset_mid();
    test_hold();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
